// File: rtl/ant_pkg.sv
// Shared types and constants for the memory arbiter and its load/store aligner.
package ant_pkg;

    // Load/store access size as encoded on ls_size.
    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } size_e;

    // Arbiter state: which access (if any) owns the memory port this cycle.
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        SERVE_IF  = 2'b01,
        SERVE_LS  = 2'b10,
        SERVE_ERR = 2'b11
    } state_e;

    // Byte-lane write enables.
    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // An access is misaligned when it does not fit its natural boundary;
    // the illegal size code is treated the same way.
    function automatic logic is_misaligned(size_e size, logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return (addr_lo != 2'b00);
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational store-data replication / byte-enable generation and
// load-data extraction with sign or zero extension.
module lsu_align
    import ant_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  addr_lo,
    input  logic        ld_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] wdata_aligned,
    output logic [3:0]  byte_en,
    output logic [31:0] rdata_ext
);

    logic [31:0] rdata_shifted;

    // Replicate store data across lanes and pick the addressed lane(s) of read data.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        wdata_aligned = '0;
        byte_en       = BE_NONE;
        rdata_ext     = '0;
        rdata_shifted = rdata >> {addr_lo, 3'b000};
        case (size)
            SIZE_BYTE: begin
                wdata_aligned = {4{wdata[7:0]}};
                byte_en       = BE_BYTE0 << addr_lo;
                rdata_ext     = ld_unsigned ? {24'b0, rdata_shifted[7:0]}
                                            : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            end
            SIZE_HALF: begin
                wdata_aligned = {2{wdata[15:0]}};
                byte_en       = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                rdata_ext     = ld_unsigned ? {16'b0, rdata_shifted[15:0]}
                                            : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            end
            SIZE_WORD: begin
                wdata_aligned = wdata;
                byte_en       = BE_WORD;
                rdata_ext     = rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch channel and a load/store channel onto one shared
// single-cycle memory port. Request accepted in cycle N, memory access in
// N+1, one-cycle response in N+2. Load/store wins unless fetch is starved.
module mem_arbiter
    import ant_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic [31:0] ls_addr,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic        ls_unsigned,
    input  logic [31:0] ls_wdata,
    output logic        ls_rsp_valid,
    output logic [31:0] ls_rsp_data,
    output logic        ls_misaligned,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_write_enable,
    output logic        store_enable,
    input  logic [31:0] mem_read_data
);

    localparam int                   STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0]  STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    state_e                state_q, state_d;
    logic [31:0]           addr_q, addr_d;
    logic                  we_q, we_d;
    size_e                 size_q, size_d;
    logic                  ld_unsigned_q, ld_unsigned_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  if_rsp_valid_q, if_rsp_valid_d;
    logic [31:0]           if_rsp_data_q, if_rsp_data_d;
    logic                  ls_rsp_valid_q, ls_rsp_valid_d;
    logic [31:0]           ls_rsp_data_q, ls_rsp_data_d;
    logic                  ls_misaligned_q, ls_misaligned_d;

    logic                  grant_ls, grant_if, ls_req_bad;
    logic [31:0]           wdata_aligned, rdata_ext;
    logic [3:0]            byte_en;

    // Fixed-priority grant with a starvation override for fetch.
    assign grant_ls     = ls_req_valid && !(if_req_valid && (starve_q == STARVE_MAX));
    assign grant_if     = if_req_valid && !grant_ls;
    assign ls_req_bad   = is_misaligned(size_e'(ls_size), ls_addr[1:0]);
    // Ready is held low while in reset so nothing is accepted before release.
    assign ls_req_ready = reset_n && grant_ls;
    assign if_req_ready = reset_n && grant_if;

    assign if_rsp_valid  = if_rsp_valid_q;
    assign if_rsp_data   = if_rsp_data_q;
    assign ls_rsp_valid  = ls_rsp_valid_q;
    assign ls_rsp_data   = ls_rsp_data_q;
    assign ls_misaligned = ls_misaligned_q;

    lsu_align u_lsu_align (
        .size          (size_q),
        .addr_lo       (addr_q[1:0]),
        .ld_unsigned   (ld_unsigned_q),
        .wdata         (wdata_q),
        .rdata         (mem_read_data),
        .wdata_aligned (wdata_aligned),
        .byte_en       (byte_en),
        .rdata_ext     (rdata_ext)
    );

    // Next state: every state accepts a new request; no grant returns to IDLE.
    always_comb begin
        state_d       = IDLE;
        addr_d        = addr_q;
        we_d          = we_q;
        size_d        = size_q;
        ld_unsigned_d = ld_unsigned_q;
        wdata_d       = wdata_q;
        if (grant_ls) begin
            state_d       = ls_req_bad ? SERVE_ERR : SERVE_LS;
            addr_d        = ls_addr;
            we_d          = ls_we;
            size_d        = size_e'(ls_size);
            ld_unsigned_d = ls_unsigned;
            wdata_d       = ls_wdata;
        end else if (grant_if) begin
            state_d       = SERVE_IF;
            addr_d        = if_addr;
            we_d          = 1'b0;
            size_d        = SIZE_WORD;
            ld_unsigned_d = 1'b0;
            wdata_d       = '0;
        end
    end

    // Starvation counter: counts load/store wins while fetch waits, saturating.
    always_comb begin
        starve_d = starve_q;
        if (!if_req_valid || grant_if) begin
            starve_d = '0;
        end else if (grant_ls && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    // Memory port drive for the access in flight and the response it produces.
    always_comb begin
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = BE_NONE;
        store_enable     = 1'b0;
        if_rsp_valid_d   = 1'b0;
        if_rsp_data_d    = '0;
        ls_rsp_valid_d   = 1'b0;
        ls_rsp_data_d    = '0;
        ls_misaligned_d  = 1'b0;
        case (state_q)
            SERVE_IF: begin
                mem_address    = {addr_q[31:2], 2'b00};
                if_rsp_valid_d = 1'b1;
                if_rsp_data_d  = mem_read_data;
            end
            SERVE_LS: begin
                mem_address    = {addr_q[31:2], 2'b00};
                ls_rsp_valid_d = 1'b1;
                if (we_q) begin
                    store_enable     = 1'b1;
                    mem_write_data   = wdata_aligned;
                    mem_write_enable = byte_en;
                end else begin
                    ls_rsp_data_d    = rdata_ext;
                end
            end
            SERVE_ERR: begin
                ls_rsp_valid_d  = 1'b1;
                ls_misaligned_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State and response registers; reset drops anything in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            we_q            <= 1'b0;
            size_q          <= SIZE_BYTE;
            ld_unsigned_q   <= 1'b0;
            wdata_q         <= '0;
            starve_q        <= '0;
            if_rsp_valid_q  <= 1'b0;
            if_rsp_data_q   <= '0;
            ls_rsp_valid_q  <= 1'b0;
            ls_rsp_data_q   <= '0;
            ls_misaligned_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q         <= state_d;
            addr_q          <= addr_d;
            we_q            <= we_d;
            size_q          <= size_d;
            ld_unsigned_q   <= ld_unsigned_d;
            wdata_q         <= wdata_d;
            starve_q        <= starve_d;
            if_rsp_valid_q  <= if_rsp_valid_d;
            if_rsp_data_q   <= if_rsp_data_d;
            ls_rsp_valid_q  <= ls_rsp_valid_d;
            ls_rsp_data_q   <= ls_rsp_data_d;
            ls_misaligned_q <= ls_misaligned_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small byte-enabled memory model.
module tb_mem_arbiter;

    logic        clock;
    logic        reset_n;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        ls_req_valid;
    logic        ls_req_ready;
    logic [31:0] ls_addr;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic        ls_unsigned;
    logic [31:0] ls_wdata;
    logic        ls_rsp_valid;
    logic [31:0] ls_rsp_data;
    logic        ls_misaligned;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_enable;
    logic        store_enable;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:63];
    int          tests_run    = 0;
    int          tests_failed = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .if_req_valid     (if_req_valid),
        .if_req_ready     (if_req_ready),
        .if_addr          (if_addr),
        .if_rsp_valid     (if_rsp_valid),
        .if_rsp_data      (if_rsp_data),
        .ls_req_valid     (ls_req_valid),
        .ls_req_ready     (ls_req_ready),
        .ls_addr          (ls_addr),
        .ls_we            (ls_we),
        .ls_size          (ls_size),
        .ls_unsigned      (ls_unsigned),
        .ls_wdata         (ls_wdata),
        .ls_rsp_valid     (ls_rsp_valid),
        .ls_rsp_data      (ls_rsp_data),
        .ls_misaligned    (ls_misaligned),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .store_enable     (store_enable),
        .mem_read_data    (mem_read_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory model: combinational read, byte-enabled write on posedge.
    assign mem_read_data = mem[mem_address[7:2]];
    always @(posedge clock) begin
        if (store_enable) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_write_enable[b]) mem[mem_address[7:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one load/store request for a single cycle; returns in cycle N+1.
    task automatic ls_issue(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata);
        ls_req_valid = 1'b1;
        ls_we        = we;
        ls_size      = size;
        ls_unsigned  = uns;
        ls_addr      = addr;
        ls_wdata     = wdata;
        tick();
        ls_req_valid = 1'b0;
        ls_we        = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        reset_n      = 1'b0;
        if_req_valid = 1'b1;
        if_addr      = '0;
        ls_req_valid = 1'b1;
        ls_addr      = '0;
        ls_we        = 1'b0;
        ls_size      = 2'b10;
        ls_unsigned  = 1'b0;
        ls_wdata     = '0;

        // Reset state: no ready even with requests pending, outputs quiet.
        #2;
        check("rst_ls_ready", 32'(ls_req_ready), 32'h0);
        check("rst_if_ready", 32'(if_req_ready), 32'h0);
        check("rst_store_en", 32'(store_enable), 32'h0);
        check("rst_mem_addr", mem_address, 32'h0);
        check("rst_ls_rsp_v", 32'(ls_rsp_valid), 32'h0);
        check("rst_if_rsp_v", 32'(if_rsp_valid), 32'h0);
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        tick();
        check("idle_we", 32'(mem_write_enable), 32'h0);
        check("idle_rsp", 32'(ls_rsp_valid), 32'h0);

        // Store word 0xDEADBEEF @0x10, then load it back.
        ls_req_valid = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h10; ls_wdata = 32'hDEAD_BEEF;
        #1;
        check("sw_ready", 32'(ls_req_ready), 32'h1);
        check("sw_if_ready", 32'(if_req_ready), 32'h0);
        tick();
        ls_req_valid = 1'b0; ls_we = 1'b0;
        check("sw_store_en", 32'(store_enable), 32'h1);
        check("sw_be", 32'(mem_write_enable), 32'hF);
        check("sw_wdata", mem_write_data, 32'hDEAD_BEEF);
        check("sw_addr", mem_address, 32'h10);
        check("sw_rsp_early", 32'(ls_rsp_valid), 32'h0);
        tick();
        check("sw_store_off", 32'(store_enable), 32'h0);
        check("sw_rsp_v", 32'(ls_rsp_valid), 32'h1);
        check("sw_rsp_d", ls_rsp_data, 32'h0);
        check("sw_mem", mem[4], 32'hDEAD_BEEF);
        tick();
        check("sw_rsp_once", 32'(ls_rsp_valid), 32'h0);
        ls_issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("lw_store_en", 32'(store_enable), 32'h0);
        check("lw_addr", mem_address, 32'h10);
        tick();
        check("lw_rsp_v", 32'(ls_rsp_valid), 32'h1);
        check("lw_rsp_d", ls_rsp_data, 32'hDEAD_BEEF);

        // Store byte 0x80 @0x21; signed then unsigned byte loads back to back.
        tick();
        ls_issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_0080);
        check("sb_be", 32'(mem_write_enable), 32'h2);
        check("sb_wdata", mem_write_data, 32'h8080_8080);
        check("sb_addr", mem_address, 32'h20);
        tick();
        check("sb_mem", mem[8], 32'hC0DE_8008);
        ls_issue(1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
        ls_req_valid = 1'b1; ls_size = 2'b00; ls_unsigned = 1'b1; ls_addr = 32'h21;
        #1;
        check("lbu_ready_b2b", 32'(ls_req_ready), 32'h1);
        tick();
        ls_req_valid = 1'b0; ls_unsigned = 1'b0;
        check("lb_rsp_v", 32'(ls_rsp_valid), 32'h1);
        check("lb_rsp_d", ls_rsp_data, 32'hFFFF_FF80);
        tick();
        check("lbu_rsp_v", 32'(ls_rsp_valid), 32'h1);
        check("lbu_rsp_d", ls_rsp_data, 32'h0000_0080);

        // Misaligned half load @0x13 and misaligned word store @0x12.
        ls_issue(1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
        check("lh_mis_store_en", 32'(store_enable), 32'h0);
        check("lh_mis_addr", mem_address, 32'h0);
        tick();
        check("lh_mis_flag", 32'(ls_misaligned), 32'h1);
        check("lh_mis_rsp_v", 32'(ls_rsp_valid), 32'h1);
        check("lh_mis_rsp_d", ls_rsp_data, 32'h0);
        ls_issue(1'b1, 2'b10, 1'b0, 32'h12, 32'h1234_5678);
        check("sw_mis_store_en", 32'(store_enable), 32'h0);
        check("sw_mis_be", 32'(mem_write_enable), 32'h0);
        tick();
        check("sw_mis_flag", 32'(ls_misaligned), 32'h1);
        check("mis_mem", mem[4], 32'hDEAD_BEEF);
        tick();
        check("mis_flag_clear", 32'(ls_misaligned), 32'h0);

        // Back-to-back fetches @0x00, 0x04, 0x0B (low bits ignored -> 0x08).
        if_req_valid = 1'b1; if_addr = 32'h00;
        #1;
        check("if_ready", 32'(if_req_ready), 32'h1);
        tick();
        if_addr = 32'h04;
        check("if0_addr", mem_address, 32'h00);
        tick();
        check("if0_rsp_v", 32'(if_rsp_valid), 32'h1);
        check("if0_rsp_d", if_rsp_data, 32'hC0DE_0000);
        check("if1_addr", mem_address, 32'h04);
        if_addr = 32'h0B;
        tick();
        if_req_valid = 1'b0;
        check("if1_rsp_v", 32'(if_rsp_valid), 32'h1);
        check("if1_rsp_d", if_rsp_data, 32'hC0DE_0001);
        check("if2_addr", mem_address, 32'h08);
        check("if2_store_en", 32'(store_enable), 32'h0);
        tick();
        check("if2_rsp_v", 32'(if_rsp_valid), 32'h1);
        check("if2_rsp_d", if_rsp_data, 32'hC0DE_0002);
        tick();
        check("if_rsp_done", 32'(if_rsp_valid), 32'h0);

        // Both channels valid continuously: LS,LS,LS,LS,IF repeating.
        if_req_valid = 1'b1; if_addr = 32'h00;
        ls_req_valid = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h10;
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("grant_%0d", k), {30'b0, if_req_ready, ls_req_ready},
                  (k % 5 == 4) ? 32'h2 : 32'h1);
            @(posedge clock);
        end
        #1;
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        repeat (3) tick();

        // Reset asserted during N+1 of a store: write must not land.
        ls_issue(1'b1, 2'b10, 1'b0, 32'h18, 32'hA5A5_A5A5);
        check("rst_st_pre", 32'(store_enable), 32'h1);
        #1 reset_n = 1'b0;
        #1;
        check("rst_st_store_en", 32'(store_enable), 32'h0);
        check("rst_st_be", 32'(mem_write_enable), 32'h0);
        @(posedge clock);
        #1;
        check("rst_st_mem", mem[6], 32'hC0DE_0006);
        check("rst_st_rsp", 32'(ls_rsp_valid), 32'h0);
        reset_n = 1'b1;
        tick();
        check("post_rst_ls_rsp", 32'(ls_rsp_valid), 32'h0);
        check("post_rst_if_rsp", 32'(if_rsp_valid), 32'h0);
        tick();
        check("post_rst_ls_rsp2", 32'(ls_rsp_valid), 32'h0);
        check("post_rst_mem", mem[6], 32'hC0DE_0006);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
